// File: rtl/div_signed_frontend_if.sv
// Request/result bus and unsigned-divider-core handshake for div_signed_frontend.
// The slave modport is the frontend's view; master is the surrounding
// environment (requester, result consumer and divider core).
interface div_signed_frontend_if #(
  parameter int DIV_WIDTH = 32
);
  // Request side
  logic                 req_valid;
  logic                 req_ready;
  logic [DIV_WIDTH-1:0] req_rs1;
  logic [DIV_WIDTH-1:0] req_rs2;
  logic [1:0]           req_op;

  // Result side
  logic                 result_valid;
  logic                 result_ready;
  logic [DIV_WIDTH-1:0] result_data;

  // Unsigned divider core handshake
  logic                 div_start;
  logic [DIV_WIDTH-1:0] div_dividend;
  logic [DIV_WIDTH-1:0] div_divisor;
  logic                 div_done;
  logic                 div_divisor_is_zero;
  logic [DIV_WIDTH-1:0] div_quotient;
  logic [DIV_WIDTH-1:0] div_remainder;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_op, result_ready,
           div_done, div_divisor_is_zero, div_quotient, div_remainder,
    output req_ready, result_valid, result_data,
           div_start, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_op, result_ready,
           div_done, div_divisor_is_zero, div_quotient, div_remainder,
    input  req_ready, result_valid, result_data,
           div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_signed_frontend.sv
// Signed/unsigned operand conditioning and result fixup in front of an
// unsigned divider core. Converts RISC-V DIV/DIVU/REM/REMU operands to
// magnitudes, launches the core, re-applies signs, applies the RISC-V
// divide-by-zero rules and reuses the last quotient/remainder pair when a
// request repeats the previous operands and signedness.
module div_signed_frontend #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,   // asynchronous, active-low
  div_signed_frontend_if.slave  bus
);

  localparam int MSB = DIV_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Control registers (reset)
  logic         r_div_start;
  logic         r_reuse_valid;
  logic [MSB:0] r_result_data;

  // Captured request (datapath, no reset)
  logic [MSB:0] r_rs1;
  logic [MSB:0] r_rs2;
  logic [1:0]   r_op;
  logic         r_neg_q;
  logic         r_neg_r;
  logic [MSB:0] r_dividend;
  logic [MSB:0] r_divisor;

  // Reuse cache (datapath, no reset; qualified by r_reuse_valid)
  logic [MSB:0] r_last_rs1;
  logic [MSB:0] r_last_rs2;
  logic         r_last_unsigned;
  logic [MSB:0] r_uq;
  logic [MSB:0] r_ur;
  logic         r_zero;

  // Combinational helpers
  logic         w_idle;
  logic         w_accept;
  logic         w_signed;
  logic         w_neg_q;
  logic         w_neg_r;
  logic         w_hit;
  logic         w_done;
  logic [MSB:0] w_result_hit;
  logic [MSB:0] w_result_done;

  // Sign re-application and divide-by-zero rule. Overflow (-2^(W-1) / -1)
  // falls out naturally: magnitude quotient 2^(W-1) is not negated.
  function automatic logic [MSB:0] fixup(
    input logic [MSB:0] uq,
    input logic [MSB:0] ur,
    input logic         zero,
    input logic         neg_q,
    input logic         neg_r,
    input logic         want_rem
  );
    logic [MSB:0] q;
    logic [MSB:0] r;
    q = zero ? {DIV_WIDTH{1'b1}} : (neg_q ? (~uq + 1'b1) : uq);
    r = neg_r ? (~ur + 1'b1) : ur;
    return want_rem ? r : q;
  endfunction

  // Request decode, reuse lookup and both candidate results
  always_comb begin
    w_idle        = (r_state == ST_IDLE);
    w_accept      = bus.req_valid && w_idle;
    w_signed      = ~bus.req_op[0];
    w_neg_q       = w_signed & (bus.req_rs1[MSB] ^ bus.req_rs2[MSB]);
    w_neg_r       = w_signed & bus.req_rs1[MSB];
    w_hit         = r_reuse_valid
                  && (bus.req_rs1 == r_last_rs1)
                  && (bus.req_rs2 == r_last_rs2)
                  && (bus.req_op[0] == r_last_unsigned);
    // A completion pulse outside WAIT (e.g. from an abandoned operation) is ignored.
    w_done        = (r_state == ST_WAIT) && bus.div_done;
    w_result_hit  = fixup(r_uq, r_ur, r_zero, w_neg_q, w_neg_r, bus.req_op[1]);
    w_result_done = fixup(bus.div_quotient, bus.div_remainder, bus.div_divisor_is_zero,
                          r_neg_q, r_neg_r, r_op[1]);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and handshake outputs
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next     = r_state;
    bus.req_ready    = 1'b0;
    bus.result_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_next = w_hit ? ST_RESULT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.div_done) begin
          w_state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Start pulse, reuse validity and the held result
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_start   <= 1'b0;
      r_reuse_valid <= 1'b0;
      r_result_data <= '0;
    end else begin
      r_div_start <= w_accept && !w_hit;
      if (w_done) begin
        r_reuse_valid <= 1'b1;
      end
      if (w_accept && w_hit) begin
        r_result_data <= w_result_hit;
      end else if (w_done) begin
        r_result_data <= w_result_done;
      end
    end
  end

  // Request capture, core operands and reuse cache
  // NOTE: these datapath registers are deliberately not reset; nothing reads
  // them until the FSM or r_reuse_valid (both reset) says they are loaded.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rs1      <= bus.req_rs1;
      r_rs2      <= bus.req_rs2;
      r_op       <= bus.req_op;
      r_neg_q    <= w_neg_q;
      r_neg_r    <= w_neg_r;
      r_dividend <= (w_signed && bus.req_rs1[MSB]) ? (~bus.req_rs1 + 1'b1) : bus.req_rs1;
      r_divisor  <= (w_signed && bus.req_rs2[MSB]) ? (~bus.req_rs2 + 1'b1) : bus.req_rs2;
    end
    if (w_done) begin
      r_uq            <= bus.div_quotient;
      r_ur            <= bus.div_remainder;
      r_zero          <= bus.div_divisor_is_zero;
      r_last_rs1      <= r_rs1;
      r_last_rs2      <= r_rs2;
      r_last_unsigned <= r_op[0];
    end
  end

  assign bus.div_start    = r_div_start;
  assign bus.div_dividend = r_dividend;
  assign bus.div_divisor  = r_divisor;
  assign bus.result_data  = r_result_data;

endmodule

// File: tb/tb_div_signed_frontend.sv
// Directed testbench for div_signed_frontend with a behavioural unsigned
// divider core that answers each start pulse a few cycles later.
`timescale 1ns/1ps
module tb_div_signed_frontend;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n_starts;

  logic [W-1:0] core_a;
  logic [W-1:0] core_b;
  int           core_cnt;

  div_signed_frontend_if #(.DIV_WIDTH(W)) bus ();

  div_signed_frontend #(.DIV_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unsigned core: independent of the frontend reset, so an
  // abandoned operation still delivers a late completion pulse.
  always @(posedge clk) begin
    bus.div_done <= 1'b0;
    if (bus.div_start) begin
      core_a   <= bus.div_dividend;
      core_b   <= bus.div_divisor;
      core_cnt <= 3;
      n_starts <= n_starts + 1;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        bus.div_done            <= 1'b1;
        bus.div_divisor_is_zero <= (core_b == '0);
        bus.div_quotient        <= (core_b == '0) ? '1     : core_a / core_b;
        bus.div_remainder       <= (core_b == '0) ? core_a : core_a % core_b;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the accepting edge; returns 1 ns after it.
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    n_tests++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: req_ready got %b expected 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int guard;
    guard = 0;
    while (!bus.result_valid && guard < 50) begin
      tick();
      guard++;
    end
    n_tests++;
    if (bus.result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: result_valid got %b expected 1", name, bus.result_valid);
    end
  endtask

  task automatic consume(input string name);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s consume: req_ready/result_valid got %b/%b expected 1/0",
               name, bus.req_ready, bus.result_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.div_start !== 1'b0
        || bus.result_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy/vld/start/data got %b/%b/%b/%h expected 1/0/0/00000000",
               bus.req_ready, bus.result_valid, bus.div_start, bus.result_data);
    end
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_div_miss();
    int s0;
    int guard;
    s0 = n_starts;
    send(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    n_tests++;
    if (bus.div_start !== 1'b1 || bus.div_dividend !== 32'd7 || bus.div_divisor !== 32'd2) begin
      n_fail++;
      $display("FAIL div_miss_start: start/dividend/divisor got %b/%h/%h expected 1/00000007/00000002",
               bus.div_start, bus.div_dividend, bus.div_divisor);
    end
    tick();
    n_tests++;
    if (bus.div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL div_miss_pulse: div_start second cycle got %b expected 0", bus.div_start);
    end
    guard = 0;
    while (!bus.div_done && guard < 50) begin
      tick();
      guard++;
    end
    n_tests++;
    if (bus.div_done !== 1'b1 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL div_miss_done: div_done/result_valid got %b/%b expected 1/0",
               bus.div_done, bus.result_valid);
    end
    tick();
    n_tests++;
    if (bus.result_valid !== 1'b1 || bus.result_data !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_miss_result: valid/data got %b/%h expected 1/fffffffd",
               bus.result_valid, bus.result_data);
    end
    n_tests++;
    if (n_starts - s0 !== 1) begin
      n_fail++;
      $display("FAIL div_miss_starts: start pulses got %0d expected 1", n_starts - s0);
    end
    consume("div_miss");
  endtask

  task automatic test_rem_reuse();
    int s0;
    s0 = n_starts;
    send(OP_REM, 32'hFFFF_FFF9, 32'd2);
    n_tests++;
    if (bus.result_valid !== 1'b1 || bus.result_data !== 32'hFFFF_FFFF || bus.div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rem_reuse: valid/data/start got %b/%h/%b expected 1/ffffffff/0",
               bus.result_valid, bus.result_data, bus.div_start);
    end
    tick();
    n_tests++;
    if (n_starts !== s0) begin
      n_fail++;
      $display("FAIL rem_reuse_starts: start pulses got %0d expected 0", n_starts - s0);
    end
    consume("rem_reuse");
  endtask

  task automatic test_div_by_zero();
    send(OP_DIVU, 32'h8000_0000, 32'h0);
    n_tests++;
    if (bus.div_dividend !== 32'h8000_0000 || bus.div_divisor !== 32'h0) begin
      n_fail++;
      $display("FAIL divu_zero_operands: dividend/divisor got %h/%h expected 80000000/00000000",
               bus.div_dividend, bus.div_divisor);
    end
    wait_result("divu_zero");
    n_tests++;
    if (bus.result_data !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL divu_zero: data got %h expected ffffffff", bus.result_data);
    end
    consume("divu_zero");
    send(OP_REM, 32'hFFFF_FFFB, 32'h0);
    wait_result("rem_zero");
    n_tests++;
    if (bus.result_data !== 32'hFFFF_FFFB) begin
      n_fail++;
      $display("FAIL rem_zero: data got %h expected fffffffb", bus.result_data);
    end
    consume("rem_zero");
  endtask

  task automatic test_overflow();
    int s0;
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    n_tests++;
    if (bus.div_dividend !== 32'h8000_0000 || bus.div_divisor !== 32'h1) begin
      n_fail++;
      $display("FAIL ovf_operands: dividend/divisor got %h/%h expected 80000000/00000001",
               bus.div_dividend, bus.div_divisor);
    end
    wait_result("ovf_div");
    n_tests++;
    if (bus.result_data !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL ovf_div: data got %h expected 80000000", bus.result_data);
    end
    consume("ovf_div");
    s0 = n_starts;
    send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    n_tests++;
    if (bus.result_valid !== 1'b1 || bus.result_data !== 32'h0 || bus.div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_rem_reuse: valid/data/start got %b/%h/%b expected 1/00000000/0",
               bus.result_valid, bus.result_data, bus.div_start);
    end
    consume("ovf_rem");
    n_tests++;
    if (n_starts !== s0) begin
      n_fail++;
      $display("FAIL ovf_rem_starts: start pulses got %0d expected 0", n_starts - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    send(OP_DIVU, 32'd100, 32'd7);
    wait_result("hold_divu");
    s0 = n_starts;
    // Next request waits while the result is held.
    bus.req_op    = OP_REMU;
    bus.req_rs1   = 32'd100;
    bus.req_rs2   = 32'd7;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (bus.result_valid !== 1'b1 || bus.result_data !== 32'd14 || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: valid/data/req_ready got %b/%h/%b expected 1/0000000e/0",
                 i, bus.result_valid, bus.result_data, bus.req_ready);
      end
    end
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: req_ready/result_valid got %b/%b expected 1/0",
               bus.req_ready, bus.result_valid);
    end
    tick();
    bus.req_valid = 1'b0;
    n_tests++;
    if (bus.result_valid !== 1'b1 || bus.result_data !== 32'd2 || n_starts !== s0) begin
      n_fail++;
      $display("FAIL b2b_remu: valid/data/starts got %b/%h/%0d expected 1/00000002/0",
               bus.result_valid, bus.result_data, n_starts - s0);
    end
    consume("b2b_remu");
  endtask

  task automatic test_async_reset_wait();
    bit seen_done;
    int s0;
    send(OP_DIV, 32'd50, 32'd3);
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus.req_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.div_start !== 1'b0
        || bus.result_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_wait: rdy/vld/start/data got %b/%b/%b/%h expected 1/0/0/00000000",
               bus.req_ready, bus.result_valid, bus.div_start, bus.result_data);
    end
    #2 rst = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.div_done) seen_done = 1'b1;
      n_tests++;
      if (bus.result_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_late_done_%0d: result_valid/req_ready got %b/%b expected 0/1",
                 i, bus.result_valid, bus.req_ready);
      end
    end
    n_tests++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL rst_late_done_seen: late div_done got 0 expected 1");
    end
    s0 = n_starts;
    send(OP_DIVU, 32'd100, 32'd7);
    n_tests++;
    if (bus.div_start !== 1'b1 || bus.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_reuse_cleared: div_start/result_valid got %b/%b expected 1/0",
               bus.div_start, bus.result_valid);
    end
    wait_result("rst_redo");
    n_tests++;
    if (bus.result_data !== 32'd14 || n_starts - s0 !== 1) begin
      n_fail++;
      $display("FAIL rst_redo: data/starts got %h/%0d expected 0000000e/1",
               bus.result_data, n_starts - s0);
    end
    consume("rst_redo");
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    n_starts         = 0;
    core_cnt         = 0;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_rs1      = '0;
    bus.req_rs2      = '0;
    bus.req_op       = 2'd0;
    bus.result_ready = 1'b0;
    #1;
    test_reset();
    test_div_miss();
    test_rem_reuse();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_async_reset_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
